// File: rtl/exec_unit_if.sv
// Instruction handshake between ctrl_unit (master) and exec_unit (slave).
interface exec_unit_if;
    logic [7:0] instr;
    logic       instr_vld;
    logic       instr_rdy;

    modport master (output instr, output instr_vld, input instr_rdy);
    modport slave  (input instr, input instr_vld, output instr_rdy);
endinterface

// File: rtl/exec_unit.sv
// Execute stage: 4-bit accumulator, zero/carry flags and a per-instruction microcode sequencer.
// Optional build macro EXEC_SAT_ARITH_EN selects saturating ADD/SUB instead of modulo-16 wrap.
module exec_unit #(
    parameter int         OUT_HOLD = 1,
    parameter logic [3:0] ACC_RST  = 4'b0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        state_i,
    exec_unit_if.slave  ctl,
    inout  wire  [3:0]  bus_io,
    output logic [3:0]  acc_o,
    output logic        zero_o,
    output logic        carry_o,
    output logic        done_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_READY, S_DECODE, S_OPERAND, S_EXECUTE, S_OUTHOLD, S_WRITEBACK
    } state_e;

    state_e     st_q, st_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] opnd_q, opnd_d;
    logic [4:0] res_q, res_d;
    logic [3:0] acc_q, acc_d;
    logic       zero_q, zero_d;
    logic       carry_q, carry_d;
    logic [1:0] hold_q, hold_d;
    logic       src, jmp, is_out, bus_oe;
    logic [1:0] op;

    // Result bit 4 is the carry (ADD) or borrow (SUB) flag.
    function automatic logic [4:0] alu_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef EXEC_SAT_ARITH_EN
        if (s[4]) s = 5'b1_1111;
`endif
        return s;
    endfunction

    function automatic logic [4:0] alu_sub(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] d;
        d = {1'b0, a} - {1'b0, b};
`ifdef EXEC_SAT_ARITH_EN
        if (d[4]) d = 5'b1_0000;
`endif
        return d;
    endfunction

    assign src    = ir_q[7];
    assign op     = ir_q[6:5];
    assign jmp    = ir_q[4];
    assign is_out = (op == 2'b11) && !src;
    assign bus_oe = (st_q == S_OUTHOLD) || ((st_q == S_WRITEBACK) && is_out && !jmp);

    assign bus_io        = bus_oe ? acc_q : 4'bzzzz;
    assign ctl.instr_rdy = (st_q == S_READY);
    assign done_o        = (st_q == S_WRITEBACK);
    assign acc_o         = acc_q;
    assign zero_o        = zero_q;
    assign carry_o       = carry_q;

    always_comb begin
        st_d    = st_q;
        ir_d    = ir_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        acc_d   = acc_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        hold_d  = hold_q;
        case (st_q)
            S_IDLE: if (state_i) st_d = S_READY;
            S_READY: begin
                if (ctl.instr_vld) begin
                    ir_d = ctl.instr;
                    st_d = S_DECODE;
                end else if (!state_i) begin
                    st_d = S_IDLE;
                end
            end
            S_DECODE: st_d = jmp ? S_WRITEBACK : S_OPERAND;
            S_OPERAND: begin
                opnd_d = src ? bus_io : ir_q[3:0];
                st_d   = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (op)
                    2'b00:   res_d = {carry_q, opnd_q};
                    2'b01:   res_d = alu_add(acc_q, opnd_q);
                    2'b10:   res_d = alu_sub(acc_q, opnd_q);
                    default: res_d = {carry_q, acc_q};
                endcase
                hold_d = 2'd0;
                st_d   = (is_out && OUT_HOLD > 1) ? S_OUTHOLD : S_WRITEBACK;
            end
            // The final bus-hold cycle overlaps WRITEBACK, so OUTHOLD covers OUT_HOLD-1 cycles.
            S_OUTHOLD: begin
                if (int'(hold_q) == OUT_HOLD - 2) st_d = S_WRITEBACK;
                else hold_d = hold_q + 2'd1;
            end
            S_WRITEBACK: begin
                if (!jmp) begin
                    acc_d   = res_q[3:0];
                    carry_d = res_q[4];
                    zero_d  = (res_q[3:0] == 4'h0);
                end
                st_d = state_i ? S_READY : S_IDLE;
            end
            default: st_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= S_IDLE;
            acc_q   <= ACC_RST;
            zero_q  <= 1'b1;
            carry_q <= 1'b0;
            hold_q  <= 2'd0;
        end else begin
            st_q    <= st_d;
            acc_q   <= acc_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            hold_q  <= hold_d;
        end
    end

    // Instruction, operand and result holding registers carry no reset.
    always_ff @(posedge clk) begin
        ir_q   <= ir_d;
        opnd_q <= opnd_d;
        res_q  <= res_d;
    end
endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of ctrl_unit. Consumes the 8-bit instr word ctrl_unit emits in run mode.
- Holds the 4-bit accumulator and the zero/carry flags. ctrl_unit's JNZ evaluation uses the zero flag.
- Runs a small microcode sequencer (DECODE, OPERAND, EXECUTE, WRITEBACK) per instruction, handshaking with ctrl_unit.
- Shares the tri-state 4-bit bus: reads it as an operand source and drives it for OUT.

Parameters:
- OUT_HOLD, 1: number of cycles the accumulator is driven on bus during OUT (1..4).
- ACC_RST, 4'b0000: accumulator value after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- state  input  1  0 = program load (unit idle), 1 = run.
- instr  input  8  instruction from ctrl_unit. Fields:
  - [7] = src: 0 immediate, 1 bus.
  - [6:5] = op.
  - [4] = jump flag.
  - [3:0] = operand.
- instr_vld  input  1  instr is valid this cycle.
- instr_rdy  output  1  unit can accept an instruction.
- bus  inout  4  shared data bus. Driven only during OUT, otherwise 4'bZ.
- acc  output  4  accumulator value.
- zero  output  1  acc == 0. Registered, updated on writeback.
- carry  output  1  carry/borrow from the last ADD/SUB.
- done  output  1  one-cycle pulse when an instruction retires.

Behaviour:
- Reset (async, any state):
  - acc = ACC_RST, zero = 1, carry = 0.
  - done = 0, instr_rdy = 0, bus released, FSM = IDLE.
  - Reset mid-instruction aborts it with no architectural update.
- IDLE: instr_rdy = 0 while state = 0. When state = 1, go to READY next cycle.
- READY: instr_rdy = 1.
  - instr_vld & instr_rdy latches instr into an internal register and moves to DECODE.
  - state dropping to 0 in READY returns to IDLE.
- DECODE:
  - instr[4] = 1 (jump): retire immediately. done = 1, no acc/flag change, back to READY. Total 2 cycles from accept.
  - Otherwise go to OPERAND.
- OPERAND:
  - src = 0: operand = instr[3:0].
  - src = 1: operand = bus sampled this cycle. Z/X bits on bus are not filtered; the bench must drive bus.
- EXECUTE (5-bit internal result):
  - op 00 LDA: acc = operand. carry unchanged.
  - op 01 ADD: {carry, acc} = acc + operand.
  - op 10 SUB: {carry, acc} = acc − operand in 5 bits. carry = 1 means borrow (acc < operand).
  - op 11 with src = 0: OUT. Drive acc on bus for OUT_HOLD cycles, starting the cycle after EXECUTE.
  - op 11 with src = 1: NOP.
- WRITEBACK:
  - acc/carry registered, then zero = (new acc == 0). For OUT/NOP, zero is recomputed from the unchanged acc.
  - done pulses 1 cycle.
  - Return to READY, or to IDLE if state = 0.
- Latency:
  - Non-jump, non-OUT instruction: 4 cycles from accept edge to done.
  - OUT: 4 + OUT_HOLD − 1 cycles.
  - instr_rdy is low from accept until the cycle after done.
- Wrap: ADD 4'hF + 4'h1 gives acc = 0, carry = 1, zero = 1. SUB 0 − 1 gives acc = 4'hF, carry = 1.
- state falling mid-instruction: the current instruction completes, then the FSM enters IDLE.
- instr_vld while instr_rdy = 0: ignored, not queued.
- bus is never driven outside OUT hold cycles. The unit never drives and samples bus in the same cycle.

Optional Feature:
- Macro: EXEC_SAT_ARITH_EN.
- Defined:
  - ADD clamps at 4'hF and SUB clamps at 4'h0.
  - carry = 1 when clamping occurred.
  - Example: 4'hF + 1 gives acc = F, carry = 1, zero = 0.
- Undefined: modulo-16 wrap as specified in Behaviour.

Test Plan:
- Reset then state = 1, LDA imm 4'h9 (0_00_0_1001) -> acc = 9, zero = 0, done pulses 4 cycles after accept, instr_rdy back high the next cycle.
- LDA 9, ADD imm 7 (0_01_0_0111) -> acc = 0, carry = 1, zero = 1. Same sequence with EXEC_SAT_ARITH_EN -> acc = F, carry = 1, zero = 0.
- SUB imm 3 from acc = 2 (0_10_0_0011) -> acc = F, carry = 1. Then LDA from bus (1_00_0_xxxx) with bench driving 4'b0101 -> acc = 5.
- OUT (0_11_0_0000) with acc = 5, OUT_HOLD = 2 -> bus = 4'b0101 for exactly 2 cycles, Z otherwise. done at accept + 5.
- Jump word 0_01_1_0011 with acc = 5 -> done 2 cycles after accept, acc/zero/carry unchanged, bus stays Z.
- Assert rst during EXECUTE of ADD -> acc = 0, zero = 1, bus Z, FSM IDLE immediately. instr_vld while instr_rdy = 0 -> no effect.
